// File: rtl/br_pkg.sv
// br_pkg: shared branch opcodes and predictor counter constants
package br_pkg;
   typedef enum logic [3:0] {
      BR_NONE = 4'd0,
      BR_EQ   = 4'd1,
      BR_NE   = 4'd2,
      BR_LEZ  = 4'd3,
      BR_GTZ  = 4'd4,
      BR_GEZ  = 4'd5,
      BR_LTZ  = 4'd6
   } br_op_e;
   localparam logic [1:0] CTR_WEAK_NT = 2'b01;
   localparam logic [1:0] CTR_WEAK_T  = 2'b10;
   function automatic int ctr_weak_t(input int w);
      return 1 << (w - 1);
   endfunction
   function automatic int ctr_weak_nt(input int w);
      return (1 << (w - 1)) - 1;
   endfunction
endpackage

// File: rtl/br_cond_eval.sv
// br_cond_eval: signed MIPS branch condition, 0 for non-branch opcodes
module br_cond_eval
   import br_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [3:0]        ex_br_op,
   input  logic [DATA_W-1:0] in0,
   input  logic [DATA_W-1:0] in1,
   output logic              taken
);
   logic neg, zero;
   assign neg   = in0[DATA_W-1];
   assign zero  = ~|in0;
   assign taken = (ex_br_op == BR_EQ)  ? (in0 == in1) :
                  (ex_br_op == BR_NE)  ? (in0 != in1) :
                  (ex_br_op == BR_LEZ) ? (neg | zero) :
                  (ex_br_op == BR_GTZ) ? (~neg & ~zero) :
                  (ex_br_op == BR_GEZ) ? ~neg :
                  (ex_br_op == BR_LTZ) ? neg : 1'b0;
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: BTB/BHT fetch prediction with EX-stage branch resolution and stats
module branch_predict_unit
   import br_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int PC_W       = 32,
   parameter int ENTRIES    = 64,
   parameter int CTR_W      = 2,
   parameter int DELAY_SLOT = 1,
   parameter int STAT_W     = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [PC_W-1:0]   if_pc,
   output logic              pred_taken,
   output logic [PC_W-1:0]   pred_target,
   input  logic              ex_valid,
   input  logic [3:0]        ex_br_op,
   input  logic [PC_W-1:0]   ex_pc,
   input  logic [DATA_W-1:0] ex_in0,
   input  logic [DATA_W-1:0] ex_in1,
   input  logic [PC_W-1:0]   ex_target,
   input  logic              ex_pred_taken,
   input  logic [PC_W-1:0]   ex_pred_target,
   output logic              ex_taken,
   output logic              mispredict,
   output logic [PC_W-1:0]   redirect_pc,
   output logic [STAT_W-1:0] stat_branches,
   output logic [STAT_W-1:0] stat_mispred
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = PC_W - IDX_W - 2;
   localparam logic [CTR_W-1:0] WEAK_T  = CTR_W'(ctr_weak_t(CTR_W));
   localparam logic [CTR_W-1:0] WEAK_NT = CTR_W'(ctr_weak_nt(CTR_W));
   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [PC_W-1:0]  target;
      logic [CTR_W-1:0] ctr;
   } btb_entry_t;
   localparam btb_entry_t RST_ENT = '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};
   btb_entry_t        tbl_q [ENTRIES];
   btb_entry_t        tbl_d [ENTRIES];
   btb_entry_t        if_ent, ex_ent;
   logic [STAT_W-1:0] branches_q, branches_d, mispred_q, mispred_d;
   logic [IDX_W-1:0]  if_idx, ex_idx;
   logic [TAG_W-1:0]  ex_tag;
   logic              br, cond, ex_hit;
   logic [3:0]        unused_bits;
   assign unused_bits = {if_pc[1:0], ex_pc[1:0]};
   assign if_idx      = if_pc[IDX_W+1:2];
   assign ex_idx      = ex_pc[IDX_W+1:2];
   assign ex_tag      = ex_pc[PC_W-1:IDX_W+2];
   assign if_ent      = tbl_q[if_idx];
   assign ex_ent      = tbl_q[ex_idx];
   assign ex_hit      = ex_ent.valid & (ex_ent.tag == ex_tag);
   assign pred_taken  = if_ent.valid & (if_ent.tag == if_pc[PC_W-1:IDX_W+2]) & if_ent.ctr[CTR_W-1];
   assign pred_target = pred_taken ? if_ent.target : '0;
   br_cond_eval #(.DATA_W(DATA_W)) u_cond (
      .ex_br_op (ex_br_op),
      .in0      (ex_in0),
      .in1      (ex_in1),
      .taken    (cond)
   );
   assign br          = ex_valid & (ex_br_op >= 4'd1) & (ex_br_op <= 4'd6);
   assign ex_taken    = br & cond;
   assign mispredict  = br & ((ex_taken != ex_pred_taken) | (ex_taken & (ex_pred_target != ex_target)));
   assign redirect_pc = !br ? '0 : ex_taken ? ex_target : ex_pc + PC_W'(DELAY_SLOT != 0 ? 8 : 4);
   assign stat_branches = branches_q;
   assign stat_mispred  = mispred_q;
   // train the resolved entry (allocate on miss) and advance statistics
   always_comb begin
      tbl_d = tbl_q;
      if (br) begin
         tbl_d[ex_idx].valid  = 1'b1;
         tbl_d[ex_idx].tag    = ex_tag;
         tbl_d[ex_idx].target = (ex_taken | !ex_hit) ? ex_target : ex_ent.target;
         tbl_d[ex_idx].ctr    = !ex_hit ? (ex_taken ? WEAK_T : WEAK_NT) :
                                ex_taken ? ((&ex_ent.ctr) ? ex_ent.ctr : ex_ent.ctr + 1'b1) :
                                ((|ex_ent.ctr) ? ex_ent.ctr - 1'b1 : ex_ent.ctr);
      end
      branches_d = branches_q + STAT_W'(br);
      mispred_d  = mispred_q + STAT_W'(mispredict);
   end
   // table and statistics registers, cleared by synchronous reset
   always_ff @(posedge clk) begin
      for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= rst_n ? tbl_d[i] : RST_ENT;
      branches_q <= rst_n ? branches_d : '0;
      mispred_q  <= rst_n ? mispred_d : '0;
   end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: scoreboard-driven scenario checks of the branch unit
module tb_branch_predict_unit;
   import br_pkg::*;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] if_pc = '0, ex_pc = '0, ex_in0 = '0, ex_in1 = '0, ex_target = '0, ex_pred_target = '0;
   logic [3:0]  ex_br_op = '0;
   logic        ex_valid = 1'b0, ex_pred_taken = 1'b0;
   logic        pred_taken, ex_taken, mispredict;
   logic [31:0] pred_target, redirect_pc, stat_branches, stat_mispred;
   typedef struct packed {
      logic        pt;
      logic [31:0] ptgt;
      logic        tk;
      logic        mp;
      logic [31:0] rd;
   } vec_t;
   typedef struct {
      string name;
      vec_t  v;
   } sb_t;
   typedef struct {
      logic        r;
      logic        v;
      logic [3:0]  op;
      logic [31:0] pc, a, b, tgt;
      logic        pt;
      logic [31:0] ptgt, ifpc;
   } stim_t;
   sb_t sb_q[$];
   int  passed = 0, total = 0, exp_br = 0, exp_mp = 0;
   always #5 clk = ~clk;
   branch_predict_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .if_pc          (if_pc),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .ex_valid       (ex_valid),
      .ex_br_op       (ex_br_op),
      .ex_pc          (ex_pc),
      .ex_in0         (ex_in0),
      .ex_in1         (ex_in1),
      .ex_target      (ex_target),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pred_target (ex_pred_target),
      .ex_taken       (ex_taken),
      .mispredict     (mispredict),
      .redirect_pc    (redirect_pc),
      .stat_branches  (stat_branches),
      .stat_mispred   (stat_mispred)
   );
   function automatic stim_t mk(input logic v, input logic [3:0] op, input logic [31:0] pc, a, b, tgt,
                                input logic pt, input logic [31:0] ptgt, ifpc);
      stim_t s;
      s.r = 1'b1; s.v = v; s.op = op; s.pc = pc; s.a = a; s.b = b;
      s.tgt = tgt; s.pt = pt; s.ptgt = ptgt; s.ifpc = ifpc;
      return s;
   endfunction
   function automatic stim_t idle(input logic [31:0] ifpc);
      return mk(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, ifpc);
   endfunction
   function automatic vec_t ev(input logic pt, input logic [31:0] ptgt, input logic tk, input logic mp,
                               input logic [31:0] rd);
      vec_t e;
      e.pt = pt; e.ptgt = ptgt; e.tk = tk; e.mp = mp; e.rd = rd;
      return e;
   endfunction
   task automatic apply(input stim_t s);
      rst_n = s.r; ex_valid = s.v; ex_br_op = s.op; ex_pc = s.pc; ex_in0 = s.a; ex_in1 = s.b;
      ex_target = s.tgt; ex_pred_taken = s.pt; ex_pred_target = s.ptgt; if_pc = s.ifpc;
   endtask
   task automatic test_reset();
      stim_t sq[$];
      vec_t  eq[$];
      sb_t   s;
      vec_t  obs;
      apply(idle(32'h0040_0010));
      rst_n = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      sq.push_back(idle(32'h0040_0010)); eq.push_back(ev(0, 0, 0, 0, 0));
      for (int i = 0; i < sq.size(); i++) begin
         apply(sq[i]);
         sb_q.push_back('{$sformatf("reset[%0d]", i), eq[i]});
         @(negedge clk);
         s = sb_q.pop_front();
         obs = '{pred_taken, pred_target, ex_taken, mispredict, redirect_pc};
         total++;
         if (obs !== s.v) $display("FAIL %s: got %h want %h", s.name, obs, s.v); else passed++;
         @(posedge clk); #1;
      end
      total++;
      if (stat_branches !== 32'd0) $display("FAIL reset_stat_branches: got %0d want 0", stat_branches); else passed++;
      total++;
      if (stat_mispred !== 32'd0) $display("FAIL reset_stat_mispred: got %0d want 0", stat_mispred); else passed++;
   endtask
   task automatic test_train();
      stim_t sq[$];
      vec_t  eq[$];
      sb_t   s;
      vec_t  obs;
      sq.push_back(mk(1, BR_EQ, 32'h0040_0010, 5, 5, 32'h0040_0100, 0, 0, 32'h0040_0010));
      eq.push_back(ev(0, 0, 1, 1, 32'h0040_0100));
      sq.push_back(idle(32'h0040_0010)); eq.push_back(ev(1, 32'h0040_0100, 0, 0, 0));
      for (int i = 0; i < sq.size(); i++) begin
         apply(sq[i]);
         sb_q.push_back('{$sformatf("train[%0d]", i), eq[i]});
         @(negedge clk);
         s = sb_q.pop_front();
         obs = '{pred_taken, pred_target, ex_taken, mispredict, redirect_pc};
         total++;
         if (obs !== s.v) $display("FAIL %s: got %h want %h", s.name, obs, s.v); else passed++;
         @(posedge clk); #1;
      end
      exp_br += 1; exp_mp += 1;
      total++;
      if (stat_branches !== exp_br) $display("FAIL train_stat_branches: got %0d want %0d", stat_branches, exp_br); else passed++;
      total++;
      if (stat_mispred !== exp_mp) $display("FAIL train_stat_mispred: got %0d want %0d", stat_mispred, exp_mp); else passed++;
   endtask
   task automatic test_saturate();
      stim_t sq[$];
      vec_t  eq[$];
      sb_t   s;
      vec_t  obs;
      logic [31:0] p = 32'h0040_0040, t = 32'h0040_0400;
      for (int k = 0; k < 4; k++) begin
         sq.push_back(mk(1, BR_LTZ, p, 32'h8000_0000, 0, t, 1, t, p));
         eq.push_back(ev(k != 0, k != 0 ? t : 32'd0, 1, 0, t));
      end
      sq.push_back(mk(1, BR_GTZ, p, 0, 0, t, 1, t, p)); eq.push_back(ev(1, t, 0, 1, 32'h0040_0048));
      sq.push_back(idle(p));                            eq.push_back(ev(1, t, 0, 0, 0));
      sq.push_back(mk(1, BR_GTZ, p, 0, 0, t, 1, t, p)); eq.push_back(ev(1, t, 0, 1, 32'h0040_0048));
      sq.push_back(idle(p));                            eq.push_back(ev(0, 0, 0, 0, 0));
      for (int i = 0; i < sq.size(); i++) begin
         apply(sq[i]);
         sb_q.push_back('{$sformatf("saturate[%0d]", i), eq[i]});
         @(negedge clk);
         s = sb_q.pop_front();
         obs = '{pred_taken, pred_target, ex_taken, mispredict, redirect_pc};
         total++;
         if (obs !== s.v) $display("FAIL %s: got %h want %h", s.name, obs, s.v); else passed++;
         @(posedge clk); #1;
      end
      exp_br += 6; exp_mp += 2;
      total++;
      if (stat_branches !== exp_br) $display("FAIL sat_stat_branches: got %0d want %0d", stat_branches, exp_br); else passed++;
   endtask
   task automatic test_bne();
      stim_t sq[$];
      vec_t  eq[$];
      sb_t   s;
      vec_t  obs;
      logic [31:0] p = 32'h0040_0020;
      sq.push_back(mk(1, BR_NE, p, 1, 1, 32'h0040_0200, 1, 32'h0040_0200, p));
      eq.push_back(ev(0, 0, 0, 1, 32'h0040_0028));
      sq.push_back(idle(p)); eq.push_back(ev(0, 0, 0, 0, 0));
      sq.push_back(mk(1, BR_NE, p, 1, 2, 32'h0040_0200, 1, 32'h0040_0204, p));
      eq.push_back(ev(0, 0, 1, 1, 32'h0040_0200));
      sq.push_back(idle(p)); eq.push_back(ev(1, 32'h0040_0200, 0, 0, 0));
      for (int i = 0; i < sq.size(); i++) begin
         apply(sq[i]);
         sb_q.push_back('{$sformatf("bne[%0d]", i), eq[i]});
         @(negedge clk);
         s = sb_q.pop_front();
         obs = '{pred_taken, pred_target, ex_taken, mispredict, redirect_pc};
         total++;
         if (obs !== s.v) $display("FAIL %s: got %h want %h", s.name, obs, s.v); else passed++;
         @(posedge clk); #1;
      end
      exp_br += 2; exp_mp += 2;
      total++;
      if (stat_mispred !== exp_mp) $display("FAIL bne_stat_mispred: got %0d want %0d", stat_mispred, exp_mp); else passed++;
   endtask
   task automatic test_alias();
      stim_t sq[$];
      vec_t  eq[$];
      sb_t   s;
      vec_t  obs;
      logic [31:0] a = 32'h0040_0010, b = 32'h0040_0110;
      sq.push_back(idle(b)); eq.push_back(ev(0, 0, 0, 0, 0));
      sq.push_back(mk(1, BR_EQ, b, 7, 7, 32'h0040_0300, 0, 0, a));
      eq.push_back(ev(1, 32'h0040_0100, 1, 1, 32'h0040_0300));
      sq.push_back(idle(b)); eq.push_back(ev(1, 32'h0040_0300, 0, 0, 0));
      sq.push_back(idle(a)); eq.push_back(ev(0, 0, 0, 0, 0));
      for (int i = 0; i < sq.size(); i++) begin
         apply(sq[i]);
         sb_q.push_back('{$sformatf("alias[%0d]", i), eq[i]});
         @(negedge clk);
         s = sb_q.pop_front();
         obs = '{pred_taken, pred_target, ex_taken, mispredict, redirect_pc};
         total++;
         if (obs !== s.v) $display("FAIL %s: got %h want %h", s.name, obs, s.v); else passed++;
         @(posedge clk); #1;
      end
      exp_br += 1; exp_mp += 1;
   endtask
   task automatic test_back_to_back();
      stim_t sq[$];
      vec_t  eq[$];
      sb_t   s;
      vec_t  obs;
      logic [3:0]  ops [12];
      logic [31:0] av [12];
      logic [31:0] bv [12];
      logic        tk [12];
      ops = '{BR_EQ, BR_EQ, BR_NE, BR_LEZ, BR_LEZ, BR_LEZ, BR_GTZ, BR_GTZ, BR_GEZ, BR_GEZ, BR_LTZ, BR_LTZ};
      av  = '{32'd5, 32'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'h8000_0000, 32'd0,
              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
      bv  = '{32'd5, 32'd6, 32'd6, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9};
      tk  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int k = 0; k < 12; k++) begin
         sq.push_back(mk(1, ops[k], 32'h0040_0800, av[k], bv[k], 32'h0040_0900, 0, 0, 32'h0040_0010));
         eq.push_back(ev(0, 0, tk[k], tk[k], tk[k] ? 32'h0040_0900 : 32'h0040_0808));
      end
      for (int i = 0; i < sq.size(); i++) begin
         apply(sq[i]);
         sb_q.push_back('{$sformatf("cond_op%0d[%0d]", sq[i].op, i), eq[i]});
         @(negedge clk);
         s = sb_q.pop_front();
         obs = '{pred_taken, pred_target, ex_taken, mispredict, redirect_pc};
         total++;
         if (obs !== s.v) $display("FAIL %s: got %h want %h", s.name, obs, s.v); else passed++;
         @(posedge clk); #1;
      end
      exp_br += 12; exp_mp += 7;
      total++;
      if (stat_branches !== exp_br) $display("FAIL b2b_stat_branches: got %0d want %0d", stat_branches, exp_br); else passed++;
      total++;
      if (stat_mispred !== exp_mp) $display("FAIL b2b_stat_mispred: got %0d want %0d", stat_mispred, exp_mp); else passed++;
   endtask
   task automatic test_no_branch();
      stim_t sq[$];
      vec_t  eq[$];
      sb_t   s;
      vec_t  obs;
      logic [31:0] q = 32'h0040_0110, tq = 32'h0040_0300;
      sq.push_back(mk(1, 4'h7, q, 3, 3, 32'h0040_0999, 1, 32'h0040_0999, q)); eq.push_back(ev(1, tq, 0, 0, 0));
      sq.push_back(mk(1, 4'hF, q, 3, 3, 32'h0040_0999, 1, 32'h0040_0999, q)); eq.push_back(ev(1, tq, 0, 0, 0));
      sq.push_back(mk(1, 4'h0, q, 3, 3, 32'h0040_0999, 1, 32'h0040_0999, q)); eq.push_back(ev(1, tq, 0, 0, 0));
      sq.push_back(mk(0, BR_NE, q, 3, 4, 32'h0040_0999, 0, 0, q));            eq.push_back(ev(1, tq, 0, 0, 0));
      sq.push_back(idle(q));                                                   eq.push_back(ev(1, tq, 0, 0, 0));
      for (int i = 0; i < sq.size(); i++) begin
         apply(sq[i]);
         sb_q.push_back('{$sformatf("nobranch[%0d]", i), eq[i]});
         @(negedge clk);
         s = sb_q.pop_front();
         obs = '{pred_taken, pred_target, ex_taken, mispredict, redirect_pc};
         total++;
         if (obs !== s.v) $display("FAIL %s: got %h want %h", s.name, obs, s.v); else passed++;
         @(posedge clk); #1;
      end
      total++;
      if (stat_branches !== exp_br) $display("FAIL nobr_stat_branches: got %0d want %0d", stat_branches, exp_br); else passed++;
      total++;
      if (stat_mispred !== exp_mp) $display("FAIL nobr_stat_mispred: got %0d want %0d", stat_mispred, exp_mp); else passed++;
   endtask
   task automatic test_reset_mid();
      stim_t sq[$];
      vec_t  eq[$];
      sb_t   s;
      vec_t  obs;
      stim_t r;
      r = mk(1, BR_EQ, 32'h0040_0800, 1, 1, 32'h0040_0900, 0, 0, 32'h0040_0110);
      r.r = 1'b0;
      sq.push_back(r); eq.push_back(ev(1, 32'h0040_0300, 1, 1, 32'h0040_0900));
      sq.push_back(idle(32'h0040_0110)); eq.push_back(ev(0, 0, 0, 0, 0));
      sq.push_back(idle(32'h0040_0800)); eq.push_back(ev(0, 0, 0, 0, 0));
      sq.push_back(idle(32'h0040_0040)); eq.push_back(ev(0, 0, 0, 0, 0));
      for (int i = 0; i < sq.size(); i++) begin
         apply(sq[i]);
         sb_q.push_back('{$sformatf("rstmid[%0d]", i), eq[i]});
         @(negedge clk);
         s = sb_q.pop_front();
         obs = '{pred_taken, pred_target, ex_taken, mispredict, redirect_pc};
         total++;
         if (obs !== s.v) $display("FAIL %s: got %h want %h", s.name, obs, s.v); else passed++;
         @(posedge clk); #1;
      end
      exp_br = 0; exp_mp = 0;
      total++;
      if (stat_branches !== exp_br) $display("FAIL rstmid_stat_branches: got %0d want %0d", stat_branches, exp_br); else passed++;
      total++;
      if (stat_mispred !== exp_mp) $display("FAIL rstmid_stat_mispred: got %0d want %0d", stat_mispred, exp_mp); else passed++;
   endtask
   initial begin
      test_reset();
      test_train();
      test_saturate();
      test_bne();
      test_alias();
      test_back_to_back();
      test_no_branch();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
